i2s_rx_stream_arbiter: RTL

Round-robin arbiter that merges the 32-bit sample streams of up to `NUM_CH` I2S/DSP receive channels into the single uDMA RX data stream. It sits in the uDMA clock domain, after the per-channel clock-domain-crossing FIFOs and before the uDMA RX channel interface. It tags every word with its source channel and can lock channel pairs (2k, 2k+1) so stereo samples stay adjacent. It flags any word a channel withdrew before it was granted.

---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_rr_pick.sv | 29 ++
 rtl/i2s_rx_stream_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Types and constants shared by the I2S RX arbiter, RX channel wrappers and TX scheduler.
package i2s_pkg;

  localparam int I2S_DW     = 32;
  localparam int I2S_MAX_CH = 16;

  // Wide enough for the largest supported channel count.
  typedef logic [$clog2(I2S_MAX_CH)-1:0] i2s_ch_t;

  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } i2s_lock_state_e;

endpackage

// File: rtl/i2s_rr_pick.sv
// Rotating-priority find-first: returns the first set request at or after ptr, modulo NUM_CH.
// Purely combinational, zero latency; no handshake of its own.
module i2s_rr_pick #(
  parameter int  NUM_CH = 4,
  localparam int PW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [PW-1:0]     gnt_idx,
  output logic              gnt_vld
);

  int idx;

  // Scan from the far end so the last hit written is the one nearest ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/i2s_rx_stream_arbiter.sv
// Round-robin merge of per-channel RX sample streams into one tagged stream, optional stereo pair lock.
// One-cycle grant-to-output latency; one-entry output register, grants only while it can load.
module i2s_rx_stream_arbiter
  import i2s_pkg::*;
#(
  parameter int  NUM_CH = 4,
  parameter int  DW     = I2S_DW,
  localparam int CHW    = $clog2(NUM_CH)
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       cfg_en_i,
  input  logic [NUM_CH-1:0]          cfg_ch_mask_i,
  input  logic                       cfg_pair_lock_i,
  input  logic                       cfg_clr_err_i,
  input  logic [NUM_CH-1:0][DW-1:0]  req_data_i,
  input  logic [NUM_CH-1:0]          req_valid_i,
  output logic [NUM_CH-1:0]          req_ready_o,
  output logic [DW-1:0]              data_o,
  output logic [CHW-1:0]             data_ch_o,
  output logic                       data_valid_o,
  input  logic                       data_ready_i,
  output logic [NUM_CH-1:0]          err_lost_o,
  output logic                       busy_o
);

  i2s_lock_state_e    lock_q, lock_d;
  logic [CHW-1:0]     ptr_q, ptr_nxt;
  logic [CHW-1:0]     lock_ch_q, lock_ch_d;
  logic [CHW-1:0]     gnt_idx;
  logic [CHW:0]       gnt_nxt;
  logic               gnt_vld, load, xfer, pair_hit;
  logic [NUM_CH-1:0]  elig, pick_req, lock_onehot, prev_pend_q;
  logic [NUM_CH:0]    mask_ext;

  assign elig        = req_valid_i & cfg_ch_mask_i & {NUM_CH{cfg_en_i}};
  assign lock_onehot = NUM_CH'(1) << lock_ch_q;
  assign pick_req    = (lock_q == LK_LOCKED) ? (elig & lock_onehot) : elig;

  i2s_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req     (pick_req),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign load        = ~data_valid_o | data_ready_i;
  assign xfer        = load & gnt_vld;
  assign req_ready_o = xfer ? (NUM_CH'(1) << gnt_idx) : '0;

  // Extra zero bit makes the partner of the last channel read as masked when NUM_CH is odd.
  assign gnt_nxt  = {1'b0, gnt_idx} + (CHW+1)'(1);
  assign mask_ext = {1'b0, cfg_ch_mask_i};
  assign pair_hit = cfg_pair_lock_i & ~gnt_idx[0] & mask_ext[gnt_nxt];
  assign ptr_nxt  = (gnt_nxt == (CHW+1)'(NUM_CH)) ? '0 : gnt_nxt[CHW-1:0];

  assign busy_o = data_valid_o | (lock_q == LK_LOCKED) | (|elig);

  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    unique case (lock_q)
      LK_UNLOCKED: begin
        if (xfer && pair_hit) begin
          lock_d    = LK_LOCKED;
          lock_ch_d = gnt_nxt[CHW-1:0];
        end
      end
      LK_LOCKED: begin
        // While locked the only possible grant is the partner, so any transfer ends the lock.
        if (!cfg_en_i || !cfg_ch_mask_i[lock_ch_q] || xfer) begin
          lock_d = LK_UNLOCKED;
        end
      end
      default: lock_d = LK_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock_q    <= LK_UNLOCKED;
      lock_ch_q <= '0;
      ptr_q     <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      if (!cfg_en_i) begin
        ptr_q <= '0;
      end else if (xfer) begin
        ptr_q <= ptr_nxt;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_o       <= '0;
      data_ch_o    <= '0;
      data_valid_o <= 1'b0;
    end else if (!cfg_en_i) begin
      data_valid_o <= 1'b0;
    end else if (xfer) begin
      data_o       <= req_data_i[gnt_idx];
      data_ch_o    <= gnt_idx;
      data_valid_o <= 1'b1;
    end else if (data_ready_i) begin
      data_valid_o <= 1'b0;
    end
  end

  // A word offered but not taken, then withdrawn, is lost; a new set beats a same-cycle clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prev_pend_q <= '0;
      err_lost_o  <= '0;
    end else begin
      prev_pend_q <= req_valid_i & ~req_ready_o & {NUM_CH{cfg_en_i}};
      err_lost_o  <= (err_lost_o & ~{NUM_CH{cfg_clr_err_i}})
                   | (prev_pend_q & ~req_valid_i & {NUM_CH{cfg_en_i}});
    end
  end

endmodule
